// File: rtl/pingpong_ram_if.sv
//------------------------------------------------------------------------------
// pingpong_ram_if : writer / reader port bundle for pingpong_ram
// Optional err bus present when PINGPONG_ERR_EN is defined.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pingpong_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) ();
  logic [ADDR_W-1:0] addra;
  logic              wea;
  logic [DATA_W-1:0] dina;
  logic              finisha;
  logic              readya;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  logic              finishb;
  logic              readyb;
`ifdef PINGPONG_ERR_EN
  logic [2:0]        err;

  modport master (
    output addra, wea, dina, finisha, addrb, finishb,
    input  readya, doutb, readyb, err
  );
  modport slave (
    input  addra, wea, dina, finisha, addrb, finishb,
    output readya, doutb, readyb, err
  );
`else
  modport master (
    output addra, wea, dina, finisha, addrb, finishb,
    input  readya, doutb, readyb
  );
  modport slave (
    input  addra, wea, dina, finisha, addrb, finishb,
    output readya, doutb, readyb
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pingpong_ram.sv
//------------------------------------------------------------------------------
// pingpong_ram : two-bank ping-pong sample store, writer fills one bank while
// the reader scans the other. Macro PINGPONG_ERR_EN adds sticky err[2:0].
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pingpong_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  wire            clk,
  input  wire            rst,
  pingpong_ram_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  logic [1:0]        r_full;
  logic              r_wsel;
  logic              r_rsel;
  logic              r_readya;
  logic              r_readyb;
  logic              r_finisha_d;
  logic              r_finishb_d;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_doutb;

  logic              w_fa_edge;
  logic              w_fb_edge;
  logic              w_set;
  logic              w_clr;
  logic              w_wr;
  logic [1:0]        w_full_nxt;
  logic              w_wsel_nxt;
  logic              w_rsel_nxt;

  assign w_fa_edge = bus.finisha & ~r_finisha_d;
  assign w_fb_edge = bus.finishb & ~r_finishb_d;
  // When both selects point at the same bank only one of these can be true,
  // so gating on the ready flags alone resolves simultaneous handoffs.
  assign w_set     = w_fa_edge & r_readya;
  assign w_clr     = w_fb_edge & r_readyb;
  assign w_wr      = bus.wea & r_readya;

  always_comb begin
    w_full_nxt = r_full;
    w_wsel_nxt = r_wsel;
    w_rsel_nxt = r_rsel;
    if (w_set) begin
      w_full_nxt[r_wsel] = 1'b1;
      w_wsel_nxt         = ~r_wsel;
    end
    if (w_clr) begin
      w_full_nxt[r_rsel] = 1'b0;
      w_rsel_nxt         = ~r_rsel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= 2'b00;
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_readya    <= 1'b1;
      r_readyb    <= 1'b0;
      r_finisha_d <= 1'b0;
      r_finishb_d <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_wsel      <= w_wsel_nxt;
      r_rsel      <= w_rsel_nxt;
      r_readya    <= ~w_full_nxt[w_wsel_nxt];
      r_readyb    <= w_full_nxt[w_rsel_nxt];
      r_finisha_d <= bus.finisha;
      r_finishb_d <= bus.finishb;
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr && !rst) begin
      mem[{r_wsel, bus.addra}] <= bus.dina;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_doutb <= '0;
    end else begin
      r_rdata <= mem[{r_rsel, bus.addrb}];
      r_doutb <= r_rdata;
    end
  end

  assign bus.readya = r_readya;
  assign bus.readyb = r_readyb;
  assign bus.doutb  = r_doutb;

`ifdef PINGPONG_ERR_EN
  logic [2:0] r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 3'b000;
    end else begin
      r_err <= r_err | {w_fb_edge & ~r_readyb,
                        w_fa_edge & ~r_readya,
                        bus.wea   & ~r_readya};
    end
  end

  assign bus.err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pingpong_ram.sv
//------------------------------------------------------------------------------
// tb_pingpong_ram : directed + random stimulus, scoreboard against a bank model
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pingpong_ram;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pingpong_ram_if #(.DATA_W(8), .ADDR_W(7)) bus ();

  pingpong_ram #(.DATA_W(8), .ADDR_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       ra;
    logic       rb;
    logic [7:0] d;
    bit         dv;
    logic [2:0] e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: bank contents and the handoff protocol as plain variables
  logic [7:0] mm [2][128];
  bit         mv [2][128];
  bit         full [2];
  int         wb, rb_i;
  bit         fa_d, fb_d;
  logic [7:0] rd1;
  bit         rd1_v;
  logic [2:0] merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input int aa, input bit we, input logic [7:0] di,
                            input bit fa, input int ab, input bit fb);
    exp_t e;
    bit   ra_m, rb_m, fae, fbe;
    int   ow, orr;
    if (r) begin
      full[0] = 0; full[1] = 0; wb = 0; rb_i = 0;
      fa_d = 0; fb_d = 0; rd1 = 8'h00; rd1_v = 1; merr = 3'b000;
      e.d = 8'h00; e.dv = 1;
    end else begin
      ra_m = !full[wb];
      rb_m = full[rb_i];
      e.d  = rd1;
      e.dv = rd1_v;
      rd1   = mm[rb_i][ab];
      rd1_v = mv[rb_i][ab];
      if (we && ra_m) begin
        mm[wb][aa] = di;
        mv[wb][aa] = 1;
      end
      fae = fa && !fa_d;
      fbe = fb && !fb_d;
      if (we && !ra_m) merr[0] = 1;
      if (fae && !ra_m) merr[1] = 1;
      if (fbe && !rb_m) merr[2] = 1;
      ow = wb; orr = rb_i;
      if (fae && ra_m) begin full[ow] = 1; wb = 1 - wb; end
      if (fbe && rb_m) begin full[orr] = 0; rb_i = 1 - rb_i; end
      fa_d = fa; fb_d = fb;
    end
    e.ra = !full[wb];
    e.rb = full[rb_i];
    e.e  = merr;
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input int aa, input bit we, input logic [7:0] di,
                       input bit fa, input int ab, input bit fb);
    rst         = r;
    bus.addra   = aa[6:0];
    bus.wea     = we;
    bus.dina    = di;
    bus.finisha = fa;
    bus.addrb   = ab[6:0];
    bus.finishb = fb;
    model_step(r, aa, we, di, fa, ab, fb);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic fill(input logic [7:0] key);
    for (int i = 0; i < 128; i++) drive(0, i, 1, i[7:0] ^ key, 0, 0, 0);
  endtask

  // Monitor: every queued expectation belongs to the rising edge just passed
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("readya", {31'd0, bus.readya}, {31'd0, e.ra});
        chk("readyb", {31'd0, bus.readyb}, {31'd0, e.rb});
        if (e.dv) chk("doutb", {24'd0, bus.doutb}, {24'd0, e.d});
`ifdef PINGPONG_ERR_EN
        chk("err", {29'd0, bus.err}, {29'd0, e.e});
`endif
      end
    end
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 128; a++) begin
        mm[b][a] = 8'h00;
        mv[b][a] = 0;
      end
    full[0] = 0; full[1] = 0; wb = 0; rb_i = 0;
    fa_d = 0; fb_d = 0; rd1 = 0; rd1_v = 0; merr = 0;

    // reset
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    idle(1);

    // fill bank0 with i, finisha held 2 cycles (one handoff)
    fill(8'h00);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    idle(2);

    // scan bank0, then release it
    for (int i = 0; i < 128; i++) drive(0, 0, 0, 8'h00, 0, i, 0);
    idle(2);
    drive(0, 0, 0, 8'h00, 0, 0, 1);
    idle(2);

    // overrun: fill and finish both banks, then a dropped write
    fill(8'hA5);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    idle(1);
    fill(8'h5A);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    idle(2);
    drive(0, 3, 1, 8'hFF, 0, 0, 0);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    idle(1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 8'h00, 0, i, 0);
    idle(2);

    // release one bank, write into it
    drive(0, 0, 0, 8'h00, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 16; i++) drive(0, i, 1, 8'h30 + i[7:0], 0, i, 0);

    // simultaneous finisha / finishb edges
    drive(0, 0, 0, 8'h00, 1, 0, 1);
    idle(3);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 8'h00, 0, i, 0);
    idle(2);

    // randomized traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom % 700) == 0,
            int'($urandom % 128), ($urandom % 2) == 0, 8'($urandom),
            ($urandom % 12) == 0,
            int'($urandom % 128), ($urandom % 12) == 0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
